// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit
// Multi-cycle multiply/divide unit holding the HI/LO registers for the E stage
// of a five-stage MIPS pipeline. The result is computed when the request is
// accepted and parked in pending registers. It becomes architecturally visible
// only after the configured number of busy cycles. The pipeline controller
// stalls HI/LO consumers on (Start | Busy).
//
// Parameters
//   MULT_CYCLES : cycles Busy stays high for mult/multu (>= 1)
//   DIV_CYCLES  : cycles Busy stays high for div/divu   (>= 1)
//
// Ports
//   Clk   in   1   rising-edge clock
//   Reset in   1   synchronous, active-high reset
//   Start in   1   one-cycle request from the E stage
//   Mdop  in   3   000 none, 001 mult, 010 multu, 011 div, 100 divu,
//                  101 mthi, 110 mtlo, 111 reserved (none)
//   A     in  32   rs operand (forwarded)
//   B     in  32   rt operand (forwarded)
//   Busy  out  1   a mult/div is in flight
//   Hi    out 32   architectural HI register
//   Lo    out 32   architectural LO register
// -----------------------------------------------------------------------------
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Mdop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    p_hi_q, p_hi_d;
    logic [31:0]    p_lo_q, p_lo_d;
    // Cleared for divide-by-zero so the commit leaves HI/LO untouched.
    logic           p_valid_q, p_valid_d;
    logic [31:0]    hi_q, hi_d;
    logic [31:0]    lo_q, lo_d;
    logic           busy_q, busy_d;

    logic [63:0]    mul_signed_s;
    logic [63:0]    mul_unsigned_s;
    logic           a_neg_s, b_neg_s;
    logic [31:0]    a_mag_s, b_mag_s;
    logic [31:0]    b_mag_safe_s, b_safe_s;
    logic [31:0]    uq_mag_s, ur_mag_s;
    logic [31:0]    div_q_s, div_r_s;
    logic [31:0]    divu_q_s, divu_r_s;

    // Arithmetic datapath: products and quotients from the current operands.
    always_comb begin
        mul_signed_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        mul_unsigned_s = {32'd0, A} * {32'd0, B};

        // Signed divide via magnitudes: |0x80000000| = 0x80000000 still fits
        // unsigned, so the overflow case falls out as Lo=0x80000000, Hi=0.
        a_neg_s = A[31];
        b_neg_s = B[31];
        a_mag_s = a_neg_s ? (~A + 32'd1) : A;
        b_mag_s = b_neg_s ? (~B + 32'd1) : B;
        // A zero divisor is replaced by 1 only to keep the datapath defined;
        // the result is never committed in that case.
        b_mag_safe_s = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
        b_safe_s     = (B == 32'd0) ? 32'd1 : B;

        uq_mag_s = a_mag_s / b_mag_safe_s;
        ur_mag_s = a_mag_s % b_mag_safe_s;
        div_q_s  = (a_neg_s ^ b_neg_s) ? (~uq_mag_s + 32'd1) : uq_mag_s;
        div_r_s  = a_neg_s ? (~ur_mag_s + 32'd1) : ur_mag_s;

        divu_q_s = A / b_safe_s;
        divu_r_s = A % b_safe_s;
    end

    // Next-state logic for the IDLE/RUN controller and HI/LO updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_hi_d    = p_hi_q;
        p_lo_d    = p_lo_q;
        p_valid_d = p_valid_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    case (Mdop)
                        OP_MULT: begin
                            p_hi_d    = mul_signed_s[63:32];
                            p_lo_d    = mul_signed_s[31:0];
                            p_valid_d = 1'b1;
                            cnt_d     = MULT_LOAD;
                            state_d   = ST_RUN;
                        end
                        OP_MULTU: begin
                            p_hi_d    = mul_unsigned_s[63:32];
                            p_lo_d    = mul_unsigned_s[31:0];
                            p_valid_d = 1'b1;
                            cnt_d     = MULT_LOAD;
                            state_d   = ST_RUN;
                        end
                        OP_DIV: begin
                            p_hi_d    = div_r_s;
                            p_lo_d    = div_q_s;
                            p_valid_d = (B != 32'd0);
                            cnt_d     = DIV_LOAD;
                            state_d   = ST_RUN;
                        end
                        OP_DIVU: begin
                            p_hi_d    = divu_r_s;
                            p_lo_d    = divu_q_s;
                            p_valid_d = (B != 32'd0);
                            cnt_d     = DIV_LOAD;
                            state_d   = ST_RUN;
                        end
                        OP_MTHI: begin
                            hi_d = A;
                        end
                        OP_MTLO: begin
                            lo_d = A;
                        end
                        default: begin
                            // none / reserved: no effect
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Requests arriving while running are ignored entirely.
                cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == {{(CW-1){1'b0}}, 1'b1}) begin
                    state_d = ST_IDLE;
                    if (p_valid_q) begin
                        hi_d = p_hi_q;
                        lo_d = p_lo_q;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
    end

    // State, counter, pending and architectural registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CW{1'b0}};
            p_hi_q    <= 32'd0;
            p_lo_q    <= 32'd0;
            p_valid_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_hi_q    <= p_hi_d;
            p_lo_q    <= p_lo_d;
            p_valid_q <= p_valid_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
        end
    end

    assign Busy = busy_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit with HI/LO registers for the E stage of the five-stage MIPS pipeline. It is the responder to the pipeline controller's hazard logic. The E-stage controller raises `Start` with an operation code. This unit answers with `Busy`, and the controller uses `Busy` to stall D-stage multiply/divide and HI/LO instructions. The unit implements mult, multu, div, divu, mthi, mtlo and exposes HI/LO for mfhi/mflo.

## Interface
- `MULT_CYCLES`, default 5: cycles `Busy` stays high for mult/multu (must be ≥1).
- `DIV_CYCLES`, default 10: cycles `Busy` stays high for div/divu (must be ≥1).

- `Clk`  input  1  sole clock, rising edge.
- `Reset`  input  1  synchronous, active-high.
- `Start`  input  1  one-cycle request from E stage. Sampled on the rising edge.
- `Mdop`  input  3  operation code:
  - 000 none
  - 001 mult
  - 010 multu
  - 011 div
  - 100 divu
  - 101 mthi
  - 110 mtlo
  - 111 reserved, treated as none.
- `A`  input  32  rs operand, already forwarded.
- `B`  input  32  rt operand, already forwarded.
- `Busy`  output  1  a mult/div is in flight.
- `Hi`  output  32  HI register.
- `Lo`  output  32  LO register.

## Operation
- **State machine:** IDLE and RUN.
  - A down-counter `cnt` (4 bits minimum, sized to the larger of the two parameters).
  - Pending result registers `pHi` and `pLo`.
- **IDLE, `Start`=1, Mdop mult/multu/div/divu:**
  - Compute the result from `A`/`B` at this edge and latch it into `pHi`/`pLo`.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`.
  - Go to RUN.
- **IDLE, `Start`=1, mthi/mtlo:**
  - Write `A` into HI (mthi) or LO (mtlo) at this edge.
  - Stay in IDLE; `Busy` stays 0.
- **IDLE, `Start`=1, none/reserved:** no effect.
- **RUN:**
  - `cnt` decrements each edge.
  - At the edge where `cnt`=1: commit `pHi`→HI and `pLo`→LO, then return to IDLE.
- **`Start` while RUN:** ignored entirely, including mthi/mtlo. The controller guarantees this does not occur.
- **Arithmetic:**
  - mult: signed 32×32→64; {HI,LO} = product.
  - multu: the same, unsigned.
  - div: signed; LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
  - divu: unsigned.
- **Boundary cases:**
  - `B`=0 on div/divu: HI and LO are left unchanged at commit. `Busy` still runs the full `DIV_CYCLES`.
  - div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- **Outputs:**
  - `Busy` = (state==RUN), registered.
  - `Hi`/`Lo` are the architectural registers. Pending values are never visible before commit.

## Timing
- **Reset:**
  - Values: `Busy`=0, `Hi`=0, `Lo`=0, state IDLE, `cnt`=0, `pHi`/`pLo`=0.
  - Reset mid-RUN discards the pending result with no commit.
  - Reset has priority over `Start` on the same edge.
- **Mult/div timing:** `Start` is high in cycle 0.
  - `Busy`=1 in cycles 1..N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
  - HI/LO show new values from cycle N+1, when `Busy`=0.
- **Back-to-back:** a new `Start` accepted in cycle N+1 is legal, with no gap cycle required.
- **Stall condition:** the controller stalls D when the D-stage instruction uses HI/LO and (`Start` | `Busy`). `Start` is combinational from E, so the unit needs no look-ahead output.
- **mthi/mtlo:** 1-cycle latency; the new value is visible in the cycle after `Start`.

## Test plan
- **Reset:** hold `Reset` 2 cycles with `Start`=1, mult, A=3, B=4 → `Busy`=0, `Hi`=`Lo`=0 throughout and after.
- **Signed mult:** mult A=0xFFFFFFFF, B=2 →
  - `Busy` high exactly cycles 1..5.
  - From cycle 6: `Hi`=0xFFFFFFFF, `Lo`=0xFFFFFFFE; unchanged during cycles 1..5.
- **Unsigned mult:** multu A=0xFFFFFFFF, B=2 → `Hi`=0x00000001, `Lo`=0xFFFFFFFE after 5 busy cycles.
- **Divides:**
  - div A=0xFFFFFFF9 (−7), B=2 → `Lo`=0xFFFFFFFD, `Hi`=0xFFFFFFFF after 10 busy cycles.
  - divu A=7, B=2 → `Lo`=3, `Hi`=1.
- **Divide boundaries:**
  - Preload via mthi 0x11 and mtlo 0x22 (each visible the next cycle), then div B=0 → `Busy` 10 cycles, `Hi`=0x11, `Lo`=0x22 unchanged.
  - div 0x80000000 / 0xFFFFFFFF → `Lo`=0x80000000, `Hi`=0.
- **Ignored requests and reset mid-op:**
  - During RUN of mult 5×6, pulse `Start` with divu 9/3 and then mtlo 0xAA → both ignored; commit gives `Hi`=0, `Lo`=30.
  - Second run: `Reset` at cycle 3 of a mult → `Busy` falls next cycle, `Hi`=`Lo`=0, no later commit.
